// File: rtl/bcd_signed_encoder.sv
// Sign + three BCD digits -> OUT_W-bit two's complement, one reverse double-dabble shift per clock.
// Latency NBITS+2 cycles from accepted start (2 on a bad digit); start ignored while busy.
module bcd_signed_encoder #(
  parameter int NBITS = 10,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [3:0]       hunds,
  input  logic [3:0]       tens,
  input  logic [3:0]       ones,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] A,
  output logic             err
);

  localparam int CW = $clog2(NBITS + 1);
  localparam logic [NBITS-1:0] POS_MAX = NBITS'(2 ** (OUT_W - 1) - 1);
  localparam logic [NBITS-1:0] NEG_MAX = NBITS'(2 ** (OUT_W - 1));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sign_q, sign_d;
  logic [11:0]      dig_q, dig_d;
  logic             bad_q, bad_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [NBITS-1:0] bin_q, bin_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] a_q, a_d;
  logic             err_q, err_d;

  logic [NBITS+11:0] sh;
  logic [11:0]       bcd_adj;
  logic              in_range;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    dig_d   = dig_q;
    bad_d   = bad_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    a_d     = a_q;
    err_d   = err_q;

    // Shift right, then pull 3 out of any nibble that received a carried-in 8.
    sh      = {bcd_q, bin_q} >> 1;
    bcd_adj = sh[NBITS+11:NBITS];
    for (int i = 0; i < 3; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd8) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] - 4'd3;
      end
    end

    in_range = sign_q ? (bin_q <= NEG_MAX) : (bin_q <= POS_MAX);

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = sign;
          dig_d   = {hunds, tens, ones};
          bad_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((dig_q[11:8] > 4'd9) || (dig_q[7:4] > 4'd9) || (dig_q[3:0] > 4'd9)) begin
          bad_d   = 1'b1;
          state_d = FINISH;
        end else begin
          bcd_d   = dig_q;
          bin_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        bin_d = sh[NBITS-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(NBITS - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (!bad_q && in_range) begin
          a_d   = sign_q ? (~bin_q[OUT_W-1:0] + 1'b1) : bin_q[OUT_W-1:0];
          err_d = 1'b0;
        end else begin
          a_d   = '0;
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      dig_q   <= '0;
      bad_q   <= 1'b0;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      dig_q   <= dig_d;
      bad_q   <= bad_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign A    = a_q;
  assign err  = err_q;

endmodule
